// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch queue, the instruction memory and the decode side.
// The slave view belongs to the queue itself; the master view is what the
// surrounding core (and imem) sees.
interface fetch_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [31:0]      imem_addr;
   logic [31:0]      imem_data;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic [31:0]      out_pc;
   logic [CNT_W-1:0] count;

   modport slave (
      output imem_addr,
      input  imem_data,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output count
   );

   modport master (
      input  imem_addr,
      output imem_data,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  count
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches sequentially from a combinational imem,
// buffers {pc, instr} pairs in a small FIFO and hands them to decode over a
// valid/ready handshake. A redirect flushes everything and restarts at the
// new target one cycle later.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic         clk,
   input logic         rst,
   fetch_queue_if.slave bus
);
   localparam int          PTR_W = $clog2(DEPTH);
   localparam int          CNT_W = PTR_W + 1;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      pc_mem_q  [DEPTH];
   logic [31:0]      ins_mem_q [DEPTH];
   logic             push;
   logic             pop;

   // Handshake decode and next-state for the fetch PC, pointers and occupancy;
   // a redirect overrides any push/pop happening in the same cycle.
   always_comb begin
      pop        = (count_q != '0) & bus.out_ready;
      push       = !bus.redirect_valid & ((count_q < CNT_W'(DEPTH)) | pop);
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   // Control state register with synchronous reset back to the boot PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Entry storage captures the fetched word alongside its PC; never cleared.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
         ins_mem_q[wr_ptr_q] <= bus.imem_data;
      end
   end

   assign bus.imem_addr = fetch_pc_q;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_instr = (count_q != '0) ? ins_mem_q[rd_ptr_q] : NOP;
   assign bus.out_pc    = (count_q != '0) ? pc_mem_q[rd_ptr_q] : 32'h0;
   assign bus.count     = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios with hand-computed values, plus
// a queue-based reference model whose expected entries are consumed by a
// negedge monitor whenever the core side accepts an instruction.
module tb_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] XORK     = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic rst;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [31:0] expPc[$];
   logic [31:0] mFetch;
   bit          modelOn = 1'b0;

   fetch_queue_if #(.DEPTH(DEPTH)) bus ();

   fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Combinational instruction memory: each word is its address xor a tag.
   assign bus.imem_data = bus.imem_addr ^ XORK;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: at each edge decide reset/flush/push and queue the expected PC.
   always @(posedge clk) begin
      if (rst) begin
         expPc.delete();
         mFetch  = RESET_PC;
         modelOn = 1'b1;
      end else if (modelOn) begin
         if (bus.redirect_valid) begin
            expPc.delete();
            mFetch = bus.redirect_pc & 32'hFFFF_FFFC;
         end else if (expPc.size() < DEPTH) begin
            expPc.push_back(mFetch);
            mFetch = mFetch + 32'd4;
         end
      end
   end

   // Monitor: compare visible outputs with the model and retire accepted entries.
   always @(negedge clk) begin
      if (modelOn) begin
         checkOutput("count", 32'(bus.count), 32'(expPc.size()));
         checkOutput("imem_addr", bus.imem_addr, mFetch);
         checkOutput("out_valid", 32'(bus.out_valid), 32'(expPc.size() != 0));
         if (expPc.size() != 0) begin
            checkOutput("out_pc", bus.out_pc, expPc[0]);
            checkOutput("out_instr", bus.out_instr, expPc[0] ^ XORK);
            if (bus.out_ready && !bus.redirect_valid && !rst) begin
               void'(expPc.pop_front());
            end
         end else begin
            checkOutput("out_pc_empty", bus.out_pc, 32'h0);
            checkOutput("out_instr_empty", bus.out_instr, 32'h0000_0013);
         end
      end
   end

   task automatic applyStimulus();
      logic [31:0] wrapPcs[4];
      wrapPcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

      rst                = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.out_ready      = 1'b0;
      tick();
      tick();
      checkOutput("reset_count", 32'(bus.count), 32'd0);
      checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_instr", bus.out_instr, 32'h0000_0013);
      checkOutput("reset_pc", bus.out_pc, 32'h0);
      checkOutput("reset_imem_addr", bus.imem_addr, RESET_PC);

      // Fill with out_ready low
      rst = 1'b0;
      repeat (4) tick();
      checkOutput("fill_count", 32'(bus.count), 32'd4);
      checkOutput("fill_imem_addr", bus.imem_addr, 32'h10);
      checkOutput("fill_head_pc", bus.out_pc, 32'h0);
      checkOutput("fill_head_instr", bus.out_instr, 32'hA5A5_0000);
      tick();
      checkOutput("full_hold_addr", bus.imem_addr, 32'h10);

      // Drain and stream from full
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checkOutput("stream_pc", bus.out_pc, 32'(4 * i));
         checkOutput("stream_count", 32'(bus.count), 32'd4);
         tick();
      end

      // Build count=3 with head 0x8, then redirect
      bus.out_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      bus.out_ready = 1'b1;
      tick();
      tick();
      bus.out_ready = 1'b0;
      tick();
      tick();
      checkOutput("pre_redirect_count", 32'(bus.count), 32'd3);
      checkOutput("pre_redirect_head", bus.out_pc, 32'h8);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h103;
      tick();
      bus.redirect_valid = 1'b0;
      checkOutput("redirect_valid_low", 32'(bus.out_valid), 32'd0);
      checkOutput("redirect_nop", bus.out_instr, 32'h0000_0013);
      checkOutput("redirect_count", 32'(bus.count), 32'd0);
      checkOutput("redirect_imem_addr", bus.imem_addr, 32'h100);
      tick();
      checkOutput("redirect_first_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("redirect_first_pc", bus.out_pc, 32'h100);
      checkOutput("redirect_first_instr", bus.out_instr, 32'hA5A5_0100);

      // Reset beats redirect
      rst                = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h200;
      tick();
      rst                = 1'b0;
      bus.redirect_valid = 1'b0;
      checkOutput("rst_vs_redirect_addr", bus.imem_addr, RESET_PC);
      checkOutput("rst_vs_redirect_count", 32'(bus.count), 32'd0);

      // Address wrap at the top of the space
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFF8;
      tick();
      bus.redirect_valid = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         checkOutput("wrap_pc", bus.out_pc, wrapPcs[i]);
         tick();
      end

      // Random backpressure with occasional redirects
      for (int i = 0; i < 1000; i++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = $urandom;
         end else begin
            bus.redirect_valid = 1'b0;
         end
         tick();
         testsRun++;
         if (32'(bus.count) > DEPTH) begin
            testsFailed++;
            $display("[TB] FAIL count_bound: got %0d, expected <= %0d", bus.count, DEPTH);
         end
      end
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;
      repeat (10) tick();
   endtask

   initial begin
      applyStimulus();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
